// File: rtl/ram_port_arbiter_if.sv
// Client/RAM-facing bundle of the two-client RAM port arbiter.
// The slave side is the arbiter; the master side is the clients plus the RAM.
interface ram_port_arbiter_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5
);
  logic [1:0]              wr_req;
  logic [2*ADDR_WIDTH-1:0] wr_addr;
  logic [2*DATA_WIDTH-1:0] wr_data;
  logic [1:0]              wr_gnt;
  logic [1:0]              rd_req;
  logic [2*ADDR_WIDTH-1:0] rd_addr;
  logic [1:0]              rd_gnt;
  logic                    rsp_valid;
  logic                    rsp_id;
  logic [DATA_WIDTH-1:0]   rsp_data;
  logic                    ram_we;
  logic [ADDR_WIDTH-1:0]   ram_write_addr;
  logic [DATA_WIDTH-1:0]   ram_data;
  logic [ADDR_WIDTH-1:0]   ram_read_addr;
  logic [DATA_WIDTH-1:0]   ram_q;

  modport slave (
    input  wr_req, wr_addr, wr_data, rd_req, rd_addr, ram_q,
    output wr_gnt, rd_gnt, rsp_valid, rsp_id, rsp_data,
           ram_we, ram_write_addr, ram_data, ram_read_addr
  );

  modport master (
    output wr_req, wr_addr, wr_data, rd_req, rd_addr, ram_q,
    input  wr_gnt, rd_gnt, rsp_valid, rsp_id, rsp_data,
           ram_we, ram_write_addr, ram_data, ram_read_addr
  );
endinterface

// File: rtl/ram_port_arbiter.sv
// Round-robin sharing of one simple dual-port RAM between two clients, with
// independent write/read arbitration and same-address write-to-read bypass.
module ram_port_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5
) (
  input logic               clk,
  input logic               rst_n,
  ram_port_arbiter_if.slave bus
);
  localparam int DW = DATA_WIDTH;
  localparam int AW = ADDR_WIDTH;

  logic          wr_ptr;
  logic          rd_ptr;
  logic [1:0]    wr_gnt;
  logic [1:0]    rd_gnt;
  logic [AW-1:0] wr_addr_mux;
  logic [DW-1:0] wr_data_mux;
  logic [AW-1:0] rd_addr_mux;
  logic [AW-1:0] wr_addr_q;
  logic [DW-1:0] wr_data_q;
  logic [AW-1:0] rd_addr_q;
  logic          rsp_valid_q;
  logic          rsp_id_q;
  logic          hit;
  logic [DW-1:0] byp_data;
  logic          collide;
  logic          rsp_valid;

  // Pointer only breaks ties; a lone requester always wins. Reset gates grants.
  always_comb begin
    wr_gnt = 2'b00;
    rd_gnt = 2'b00;
    if (rst_n) begin
      wr_gnt = (bus.wr_req == 2'b11) ? (wr_ptr ? 2'b10 : 2'b01) : bus.wr_req;
      rd_gnt = (bus.rd_req == 2'b11) ? (rd_ptr ? 2'b10 : 2'b01) : bus.rd_req;
    end
  end

  // Without a grant the RAM address/data lines keep the last granted values.
  always_comb begin
    wr_addr_mux = wr_addr_q;
    wr_data_mux = wr_data_q;
    rd_addr_mux = rd_addr_q;
    if (|wr_gnt) begin
      wr_addr_mux = wr_gnt[1] ? bus.wr_addr[AW +: AW] : bus.wr_addr[0 +: AW];
      wr_data_mux = wr_gnt[1] ? bus.wr_data[DW +: DW] : bus.wr_data[0 +: DW];
    end
    if (|rd_gnt) begin
      rd_addr_mux = rd_gnt[1] ? bus.rd_addr[AW +: AW] : bus.rd_addr[0 +: AW];
    end
  end

  assign collide = (|wr_gnt) && (|rd_gnt) && (wr_addr_mux == rd_addr_mux);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      rd_addr_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      hit         <= 1'b0;
      byp_data    <= '0;
    end else begin
      if (|wr_gnt) begin
        wr_ptr    <= wr_gnt[0];
        wr_addr_q <= wr_addr_mux;
        wr_data_q <= wr_data_mux;
      end
      if (|rd_gnt) begin
        rd_ptr    <= rd_gnt[0];
        rd_addr_q <= rd_addr_mux;
      end
      rsp_valid_q <= |rd_gnt;
      rsp_id_q    <= rd_gnt[1];
      hit         <= collide;
      if (collide) begin
        byp_data <= wr_data_mux;
      end
    end
  end

  // The RAM returns pre-write data on a collision, so the bypass copy wins.
  assign rsp_valid          = rsp_valid_q & rst_n;
  assign bus.rsp_valid      = rsp_valid;
  assign bus.rsp_id         = rsp_id_q;
  assign bus.rsp_data       = !rsp_valid ? '0 : (hit ? byp_data : bus.ram_q);
  assign bus.wr_gnt         = wr_gnt;
  assign bus.rd_gnt         = rd_gnt;
  assign bus.ram_we         = |wr_gnt;
  assign bus.ram_write_addr = wr_addr_mux;
  assign bus.ram_data       = wr_data_mux;
  assign bus.ram_read_addr  = rd_addr_mux;
endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench for ram_port_arbiter: directed scenarios plus a
// randomized run checked against a memory/turn-based reference model.
module tb_ram_port_arbiter;
  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  ram_port_arbiter_if #(.DATA_WIDTH(8), .ADDR_WIDTH(5)) bus ();

  ram_port_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(5)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural RAM: registered read that returns the pre-write contents.
  logic [7:0] mem [32];
  always @(posedge clk) begin
    if (bus.ram_we) mem[bus.ram_write_addr] <= bus.ram_data;
    bus.ram_q <= mem[bus.ram_read_addr];
  end

  // Reference model state: whose turn it is on each side and what memory holds.
  int         m_wturn;
  int         m_rturn;
  logic [7:0] ref_mem [32];
  bit         pend_v;
  int         pend_id;
  logic [7:0] pend_d;

  logic [1:0] o_wg, o_rg, e_wg, e_rg;
  logic       o_we, o_rv, o_rid, e_we, e_rv, e_rid;
  logic [4:0] o_waddr, o_raddr, e_waddr, e_raddr;
  logic [7:0] o_wdata, o_rdata, e_wdata, e_rdata;

  function automatic int winner(input logic [1:0] q, input int turn);
    if (q[0] && q[1]) return turn;
    if (q[0]) return 0;
    if (q[1]) return 1;
    return -1;
  endfunction

  task automatic run_cycle(input logic r, input logic [1:0] wq,
                           input logic [4:0] wa0, input logic [4:0] wa1,
                           input logic [7:0] wd0, input logic [7:0] wd1,
                           input logic [1:0] rq,
                           input logic [4:0] ra0, input logic [4:0] ra1);
    int wi, ri;
    rst_n       = r;
    bus.wr_req  = wq;
    bus.wr_addr = {wa1, wa0};
    bus.wr_data = {wd1, wd0};
    bus.rd_req  = rq;
    bus.rd_addr = {ra1, ra0};
    @(negedge clk);
    o_wg = bus.wr_gnt;  o_rg = bus.rd_gnt;  o_we = bus.ram_we;
    o_waddr = bus.ram_write_addr;  o_wdata = bus.ram_data;
    o_raddr = bus.ram_read_addr;
    o_rv = bus.rsp_valid;  o_rid = bus.rsp_id;  o_rdata = bus.rsp_data;
    wi = r ? winner(wq, m_wturn) : -1;
    ri = r ? winner(rq, m_rturn) : -1;
    e_wg    = (wi < 0) ? 2'b00 : ((wi == 1) ? 2'b10 : 2'b01);
    e_rg    = (ri < 0) ? 2'b00 : ((ri == 1) ? 2'b10 : 2'b01);
    e_we    = (wi >= 0);
    e_waddr = (wi == 1) ? wa1 : wa0;
    e_wdata = (wi == 1) ? wd1 : wd0;
    e_raddr = (ri == 1) ? ra1 : ra0;
    e_rv    = r && pend_v;
    e_rid   = (pend_id == 1);
    e_rdata = e_rv ? pend_d : 8'h00;
    if (!r) begin
      m_wturn = 0;
      m_rturn = 0;
      pend_v  = 0;
    end else begin
      if (wi >= 0) begin
        ref_mem[e_waddr] = e_wdata;
        m_wturn = 1 - wi;
      end
      pend_v = (ri >= 0);
      if (ri >= 0) begin
        pend_id = ri;
        pend_d  = ref_mem[e_raddr];
        m_rturn = 1 - ri;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    run_cycle(1'b0, 2'b11, 5'd1, 5'd2, 8'h11, 8'h22, 2'b11, 5'd1, 5'd2);
    total++; if (o_wg !== 2'b00) begin bad++; $display("[TB] FAIL reset_wr_gnt got=%b exp=00", o_wg); end
    total++; if (o_rg !== 2'b00) begin bad++; $display("[TB] FAIL reset_rd_gnt got=%b exp=00", o_rg); end
    total++; if (o_we !== 1'b0) begin bad++; $display("[TB] FAIL reset_ram_we got=%b exp=0", o_we); end
    run_cycle(1'b0, 2'b11, 5'd1, 5'd2, 8'h11, 8'h22, 2'b11, 5'd1, 5'd2);
    total++; if (o_rv !== 1'b0) begin bad++; $display("[TB] FAIL reset_rsp_valid got=%b exp=0", o_rv); end
    total++; if (o_rdata !== 8'h00) begin bad++; $display("[TB] FAIL reset_rsp_data got=%h exp=00", o_rdata); end
  endtask

  task automatic init_mem();
    for (int i = 0; i < 32; i++) begin
      run_cycle(1'b1, (i % 2 == 0) ? 2'b01 : 2'b10, 5'(i), 5'(i), 8'(i * 7 + 3), 8'(i * 7 + 3),
                2'b00, 5'd0, 5'd0);
      total++; if (o_we !== 1'b1 || o_waddr !== 5'(i)) begin
        bad++; $display("[TB] FAIL init_write we=%b addr=%0d exp we=1 addr=%0d", o_we, o_waddr, i);
      end
    end
  endtask

  task automatic test_write_read();
    run_cycle(1'b1, 2'b10, 5'd0, 5'd3, 8'h00, 8'hA5, 2'b00, 5'd0, 5'd0);
    total++; if (o_wg !== 2'b10) begin bad++; $display("[TB] FAIL wr_c1_gnt got=%b exp=10", o_wg); end
    total++; if (o_waddr !== 5'd3 || o_wdata !== 8'hA5) begin
      bad++; $display("[TB] FAIL wr_c1_bus addr=%0d data=%h exp addr=3 data=a5", o_waddr, o_wdata);
    end
    run_cycle(1'b1, 2'b00, 5'd0, 5'd0, 8'h00, 8'h00, 2'b01, 5'd3, 5'd0);
    total++; if (o_rg !== 2'b01) begin bad++; $display("[TB] FAIL rd_c0_gnt got=%b exp=01", o_rg); end
    total++; if (o_raddr !== 5'd3) begin bad++; $display("[TB] FAIL rd_c0_addr got=%0d exp=3", o_raddr); end
    run_cycle(1'b1, 2'b00, 5'd0, 5'd0, 8'h00, 8'h00, 2'b00, 5'd0, 5'd0);
    total++; if (o_rv !== 1'b1 || o_rid !== 1'b0 || o_rdata !== 8'hA5) begin
      bad++; $display("[TB] FAIL rd_c0_rsp v=%b id=%b data=%h exp v=1 id=0 data=a5", o_rv, o_rid, o_rdata);
    end
    run_cycle(1'b1, 2'b00, 5'd0, 5'd0, 8'h00, 8'h00, 2'b00, 5'd0, 5'd0);
    total++; if (o_rv !== 1'b0 || o_rdata !== 8'h00) begin
      bad++; $display("[TB] FAIL idle_rsp v=%b data=%h exp v=0 data=00", o_rv, o_rdata);
    end
  endtask

  task automatic test_write_rr();
    logic [1:0] exp_seq [4];
    exp_seq = '{2'b01, 2'b10, 2'b01, 2'b10};
    run_cycle(1'b0, 2'b00, 5'd0, 5'd0, 8'h00, 8'h00, 2'b00, 5'd0, 5'd0);
    for (int i = 0; i < 4; i++) begin
      run_cycle(1'b1, 2'b11, 5'd10, 5'd11, 8'(8'h40 + i), 8'(8'h50 + i), 2'b00, 5'd0, 5'd0);
      total++; if (o_wg !== exp_seq[i] || o_we !== 1'b1) begin
        bad++; $display("[TB] FAIL wr_rr[%0d] gnt=%b we=%b exp gnt=%b we=1", i, o_wg, o_we, exp_seq[i]);
      end
    end
  endtask

  task automatic test_bypass();
    run_cycle(1'b1, 2'b01, 5'd7, 5'd0, 8'h11, 8'h00, 2'b00, 5'd0, 5'd0);
    run_cycle(1'b1, 2'b01, 5'd7, 5'd0, 8'h22, 8'h00, 2'b10, 5'd0, 5'd7);
    total++; if (o_wg !== 2'b01 || o_rg !== 2'b10) begin
      bad++; $display("[TB] FAIL collide_gnt wr=%b rd=%b exp wr=01 rd=10", o_wg, o_rg);
    end
    // A different-address write alongside the read of @7 must not bypass.
    run_cycle(1'b1, 2'b01, 5'd8, 5'd0, 8'h33, 8'h00, 2'b01, 5'd7, 5'd0);
    total++; if (o_rv !== 1'b1 || o_rid !== 1'b1 || o_rdata !== 8'h22) begin
      bad++; $display("[TB] FAIL bypass_rsp v=%b id=%b data=%h exp v=1 id=1 data=22", o_rv, o_rid, o_rdata);
    end
    run_cycle(1'b1, 2'b00, 5'd0, 5'd0, 8'h00, 8'h00, 2'b00, 5'd0, 5'd0);
    total++; if (o_rv !== 1'b1 || o_rid !== 1'b0 || o_rdata !== 8'h22) begin
      bad++; $display("[TB] FAIL reread7_rsp v=%b id=%b data=%h exp v=1 id=0 data=22", o_rv, o_rid, o_rdata);
    end
  endtask

  task automatic test_back_to_back();
    logic exp_id [3];
    exp_id = '{1'b0, 1'b1, 1'b0};
    run_cycle(1'b0, 2'b00, 5'd0, 5'd0, 8'h00, 8'h00, 2'b00, 5'd0, 5'd0);
    for (int i = 0; i < 4; i++) begin
      if (i < 3) run_cycle(1'b1, 2'b00, 5'd0, 5'd0, 8'h00, 8'h00, 2'b11, 5'd1, 5'd2);
      else       run_cycle(1'b1, 2'b00, 5'd0, 5'd0, 8'h00, 8'h00, 2'b00, 5'd0, 5'd0);
      if (i > 0) begin
        total++; if (o_rv !== 1'b1 || o_rid !== exp_id[i-1] || o_rdata !== e_rdata) begin
          bad++; $display("[TB] FAIL b2b_rsp[%0d] v=%b id=%b data=%h exp v=1 id=%b data=%h",
                          i - 1, o_rv, o_rid, o_rdata, exp_id[i-1], e_rdata);
        end
      end
    end
  endtask

  task automatic test_reset_drop();
    run_cycle(1'b1, 2'b01, 5'd4, 5'd5, 8'h66, 8'h77, 2'b01, 5'd4, 5'd5);
    total++; if (o_rg !== 2'b01) begin bad++; $display("[TB] FAIL drop_pre_gnt got=%b exp=01", o_rg); end
    run_cycle(1'b0, 2'b11, 5'd4, 5'd5, 8'h66, 8'h77, 2'b11, 5'd4, 5'd5);
    total++; if (o_rv !== 1'b0 || o_rg !== 2'b00) begin
      bad++; $display("[TB] FAIL drop_rsp v=%b rd_gnt=%b exp v=0 rd_gnt=00", o_rv, o_rg);
    end
    run_cycle(1'b1, 2'b11, 5'd4, 5'd5, 8'h66, 8'h77, 2'b11, 5'd4, 5'd5);
    total++; if (o_wg !== 2'b01 || o_rg !== 2'b01 || o_rv !== 1'b0) begin
      bad++; $display("[TB] FAIL drop_ptr wr=%b rd=%b v=%b exp wr=01 rd=01 v=0", o_wg, o_rg, o_rv);
    end
    run_cycle(1'b1, 2'b00, 5'd0, 5'd0, 8'h00, 8'h00, 2'b00, 5'd0, 5'd0);
  endtask

  task automatic test_random();
    logic [1:0] wq, rq;
    logic [4:0] wa [2];
    logic [4:0] ra [2];
    logic [7:0] wd [2];
    wq = 2'b00;
    rq = 2'b00;
    for (int n = 0; n < 400; n++) begin
      for (int c = 0; c < 2; c++) begin
        if (!wq[c]) begin
          wq[c] = ($urandom_range(0, 3) != 0);
          wa[c] = 5'($urandom_range(0, 7));
          wd[c] = 8'($urandom);
        end
        if (!rq[c]) begin
          rq[c] = ($urandom_range(0, 3) != 0);
          ra[c] = 5'($urandom_range(0, 7));
        end
      end
      run_cycle(1'b1, wq, wa[0], wa[1], wd[0], wd[1], rq, ra[0], ra[1]);
      total++; if (o_wg !== e_wg || o_rg !== e_rg || o_we !== e_we) begin
        bad++; $display("[TB] FAIL rnd_gnt[%0d] wr=%b rd=%b we=%b exp wr=%b rd=%b we=%b",
                        n, o_wg, o_rg, o_we, e_wg, e_rg, e_we);
      end
      total++; if (o_rv !== e_rv || o_rdata !== e_rdata || (e_rv && o_rid !== e_rid)) begin
        bad++; $display("[TB] FAIL rnd_rsp[%0d] v=%b id=%b data=%h exp v=%b id=%b data=%h",
                        n, o_rv, o_rid, o_rdata, e_rv, e_rid, e_rdata);
      end
      if (e_we) begin
        total++; if (o_waddr !== e_waddr || o_wdata !== e_wdata) begin
          bad++; $display("[TB] FAIL rnd_wbus[%0d] addr=%0d data=%h exp addr=%0d data=%h",
                          n, o_waddr, o_wdata, e_waddr, e_wdata);
        end
      end
      if (e_rg != 2'b00) begin
        total++; if (o_raddr !== e_raddr) begin
          bad++; $display("[TB] FAIL rnd_raddr[%0d] got=%0d exp=%0d", n, o_raddr, e_raddr);
        end
      end
      wq = wq & ~e_wg;
      rq = rq & ~e_rg;
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired before end of sequence");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    total       = 0;
    bad         = 0;
    m_wturn     = 0;
    m_rturn     = 0;
    pend_v      = 0;
    pend_id     = 0;
    pend_d      = 8'h00;
    rst_n       = 1'b0;
    bus.wr_req  = 2'b00;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.rd_req  = 2'b00;
    bus.rd_addr = '0;
    for (int i = 0; i < 32; i++) ref_mem[i] = 8'h00;
    @(posedge clk);
    #1;
    test_reset();
    init_mem();
    test_write_read();
    test_write_rr();
    test_bypass();
    test_back_to_back();
    test_reset_drop();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
